// File: rtl/wb_stage_writer_if.sv
// Bundle between the memory stage, the MEM/WB register and the register-bank write port.
// The master modport is the writeback stage. The slave modport is its environment.
interface wb_stage_writer_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             stall;
   logic             flush;
   logic             in_valid;
   logic             in_reg_write;
   logic [4:0]       in_rd;
   logic [1:0]       in_wb_sel;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_alu_result;
   logic [XLEN-1:0]  in_mem_rdata;
   logic [XLEN-1:0]  in_pc_plus4;
   logic [4:0]       rd;
   logic             RegWrite;
   logic [XLEN-1:0]  C;
   logic             wb_valid;
   logic [CNT_W-1:0] retire_count;

   modport master (
      input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
             in_alu_result, in_mem_rdata, in_pc_plus4,
      output rd, RegWrite, C, wb_valid, retire_count
   );

   modport slave (
      output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
             in_alu_result, in_mem_rdata, in_pc_plus4,
      input  rd, RegWrite, C, wb_valid, retire_count
   );
endinterface

// File: rtl/wb_stage_writer.sv
// MEM/WB pipeline register with RV32I load extraction, writeback source select,
// a registered register-bank write port and a retired-instruction counter.
module wb_stage_writer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   wb_stage_writer_if.master  wb
);
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             wb_valid_q, wb_valid_d;
   logic             reg_write_q, reg_write_d;
   logic [4:0]       rd_q, rd_d;
   logic [XLEN-1:0]  c_q, c_d;
   logic [CNT_W-1:0] retire_count_q, retire_count_d;

   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [XLEN-1:0]  ld_data;
   logic [XLEN-1:0]  wb_data;

   // Data memory returns the aligned word, so the low address bits pick the lane.
   always_comb begin
      ld_byte = wb.in_mem_rdata[{wb.in_alu_result[1:0], 3'b000} +: 8];
      ld_half = wb.in_mem_rdata[{wb.in_alu_result[1], 4'b0000} +: 16];
      case (wb.in_funct3)
         F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
         F3_LW:   ld_data = wb.in_mem_rdata;
         default: ld_data = '0;
      endcase
   end

   // The reserved encoding 11 falls through to the ALU result.
   always_comb begin
      case (wb.in_wb_sel)
         SEL_LOAD: wb_data = ld_data;
         SEL_PC4:  wb_data = wb.in_pc_plus4;
         default:  wb_data = wb.in_alu_result;
      endcase
   end

   always_comb begin
      wb_valid_d     = wb_valid_q;
      reg_write_d    = reg_write_q;
      rd_d           = rd_q;
      c_d            = c_q;
      retire_count_d = retire_count_q;
      if (wb.flush) begin
         wb_valid_d  = 1'b0;
         reg_write_d = 1'b0;
      end else if (!wb.stall) begin
         wb_valid_d  = wb.in_valid;
         reg_write_d = wb.in_valid & wb.in_reg_write;
         rd_d        = wb.in_rd;
         c_d         = wb_data;
         if (wb.in_valid) begin
            retire_count_d = retire_count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q     <= 1'b0;
         reg_write_q    <= 1'b0;
         rd_q           <= 5'd0;
         c_q            <= '0;
         retire_count_q <= '0;
      end else begin
         wb_valid_q     <= wb_valid_d;
         reg_write_q    <= reg_write_d;
         rd_q           <= rd_d;
         c_q            <= c_d;
         retire_count_q <= retire_count_d;
      end
   end

   // x0 is never written: the enable is suppressed here rather than in the bank.
   assign wb.RegWrite     = wb_valid_q & reg_write_q & (rd_q != 5'd0);
   assign wb.rd           = rd_q;
   assign wb.C            = c_q;
   assign wb.wb_valid     = wb_valid_q;
   assign wb.retire_count = retire_count_q;
endmodule

// File: tb/tb_wb_stage_writer.sv
// Bench for wb_stage_writer: directed cases plus random traffic against a reference model.
// A second instance with a 3-bit retire counter exercises counter wrap in a short run.
module tb_wb_stage_writer;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, in_valid, in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;

   int errors = 0;
   int checks = 0;

   wb_stage_writer_if #(.XLEN(32), .CNT_W(32)) ifm ();
   wb_stage_writer_if #(.XLEN(32), .CNT_W(3))  ifs ();

   assign ifm.stall = stall;          assign ifs.stall = stall;
   assign ifm.flush = flush;          assign ifs.flush = flush;
   assign ifm.in_valid = in_valid;    assign ifs.in_valid = in_valid;
   assign ifm.in_reg_write = in_reg_write;   assign ifs.in_reg_write = in_reg_write;
   assign ifm.in_rd = in_rd;          assign ifs.in_rd = in_rd;
   assign ifm.in_wb_sel = in_wb_sel;  assign ifs.in_wb_sel = in_wb_sel;
   assign ifm.in_funct3 = in_funct3;  assign ifs.in_funct3 = in_funct3;
   assign ifm.in_alu_result = in_alu_result; assign ifs.in_alu_result = in_alu_result;
   assign ifm.in_mem_rdata = in_mem_rdata;   assign ifs.in_mem_rdata = in_mem_rdata;
   assign ifm.in_pc_plus4 = in_pc_plus4;     assign ifs.in_pc_plus4 = in_pc_plus4;

   wb_stage_writer #(.XLEN(32), .CNT_W(32)) u_dut   (.clk(clk), .rst(rst), .wb(ifm));
   wb_stage_writer #(.XLEN(32), .CNT_W(3))  u_small (.clk(clk), .rst(rst), .wb(ifs));

   always #5 clk = ~clk;

   // Reference model state; rd/C are unspecified after a flush, hence m_known.
   bit          m_valid, m_we, m_known;
   logic [4:0]  m_rd;
   logic [31:0] m_c;
   longint      m_cnt;
   int          m_cnt_s;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [2:0] f3,
                                          input logic [31:0] alu, input logic [31:0] mem,
                                          input logic [31:0] pc4);
      longint v;
      int     sh;
      if (sel == 2'd2) return pc4;
      if (sel != 2'd1) return alu;
      case (f3)
         3'd0, 3'd4: begin
            sh = int'(alu % 4) * 8;
            v  = longint'((mem >> sh) % 256);
            if (f3 == 3'd0 && v >= 128) v -= 256;
         end
         3'd1, 3'd5: begin
            sh = (int'(alu % 4) / 2) * 16;
            v  = longint'((mem >> sh) % 65536);
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
         end
         3'd2:    v = longint'(mem);
         default: v = 0;
      endcase
      return v[31:0];
   endfunction

   task automatic step();
      bit          nv, nwe, nk;
      logic [4:0]  nrd;
      logic [31:0] nc;
      longint      ncnt;
      int          ncs;
      nv = m_valid; nwe = m_we; nk = m_known; nrd = m_rd; nc = m_c;
      ncnt = m_cnt; ncs = m_cnt_s;
      if (rst) begin
         nv = 0; nwe = 0; nk = 1; nrd = 0; nc = 0; ncnt = 0; ncs = 0;
      end else if (flush) begin
         nv = 0; nwe = 0; nk = 0;
      end else if (!stall) begin
         nv  = in_valid;
         nwe = in_valid && in_reg_write;
         nrd = in_rd;
         nc  = ref_wb(in_wb_sel, in_funct3, in_alu_result, in_mem_rdata, in_pc_plus4);
         nk  = 1;
         if (in_valid) begin
            ncnt = (m_cnt + 1) % 64'h1_0000_0000;
            ncs  = (m_cnt_s + 1) % 8;
         end
      end
      @(posedge clk);
      #1;
      m_valid = nv; m_we = nwe; m_known = nk; m_rd = nrd; m_c = nc;
      m_cnt = ncnt; m_cnt_s = ncs;
      chk("wb_valid", {31'd0, ifm.wb_valid}, {31'd0, m_valid});
      chk("regwrite", {31'd0, ifm.RegWrite}, {31'd0, (m_valid && m_we && m_rd != 0)});
      chk("retire_count", ifm.retire_count, m_cnt[31:0]);
      chk("retire_count_w3", {29'd0, ifs.retire_count}, m_cnt_s);
      if (m_known) begin
         chk("rd", {27'd0, ifm.rd}, {27'd0, m_rd});
         chk("C", ifm.C, m_c);
      end
   endtask

   task automatic drive(input bit v, input bit we, input logic [4:0] r, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc4);
      stall = 0; flush = 0;
      in_valid = v; in_reg_write = we; in_rd = r; in_wb_sel = sel; in_funct3 = f3;
      in_alu_result = alu; in_mem_rdata = mem; in_pc_plus4 = pc4;
   endtask

   logic [2:0]  ld_f3  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
   logic [1:0]  ld_off [6] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
   logic [31:0] ld_exp [6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080,
                               32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

   initial begin
      m_valid = 0; m_we = 0; m_known = 0; m_rd = 0; m_c = 0; m_cnt = 0; m_cnt_s = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1;
      step();
      step();
      chk("reset_c", ifm.C, 32'h0);
      rst = 0;

      drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
      step();
      chk("alu_c", ifm.C, 32'h0000_1234);
      chk("alu_cnt", ifm.retire_count, 32'd1);

      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 5'd3, 2'b01, ld_f3[i], {30'd0, ld_off[i]}, 32'h80FF_7F01, 32'h0);
         step();
         chk("load_c", ifm.C, ld_exp[i]);
      end

      drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
      step();
      chk("x0_regwrite", {31'd0, ifm.RegWrite}, 32'd0);

      drive(1, 1, 5'd1, 2'b10, 3'd0, 32'h0, 32'h0, 32'h0000_0104);
      step();
      chk("jal_c", ifm.C, 32'h0000_0104);
      chk("jal_regwrite", {31'd0, ifm.RegWrite}, 32'd1);

      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h5555_0000 + i, 32'h0, 32'h0);
         stall = 1;
         step();
         chk("stall_c", ifm.C, 32'h0000_0104);
         chk("stall_cnt", ifm.retire_count, 32'd9);
      end

      drive(1, 1, 5'd7, 2'b00, 3'd0, 32'h1111_1111, 32'h0, 32'h0);
      stall = 1; flush = 1;
      step();
      chk("flush_valid", {31'd0, ifm.wb_valid}, 32'd0);

      drive(1, 1, 5'd12, 2'b00, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
      step();
      drive(1, 1, 5'd13, 2'b00, 3'd0, 32'hCAFE_0002, 32'h0, 32'h0);
      stall = 1; flush = 1;
      rst = 1;
      step();
      rst = 0;
      chk("midrst_c", ifm.C, 32'h0);
      chk("midrst_cnt", ifm.retire_count, 32'd0);

      for (int i = 0; i < 10; i++) begin
         drive(1, i % 2, 5'(i + 1), 2'b00, 3'd0, 32'(i), 32'h0, 32'h0);
         step();
      end
      chk("wrap_w3", {29'd0, ifs.retire_count}, 32'd2);

      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
         stall = ($urandom_range(0, 99) < 15);
         flush = ($urandom_range(0, 99) < 10);
         rst   = ($urandom_range(0, 99) < 2);
         step();
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
